// File: rtl/div_rem_pkg.sv
// rtl/div_rem_pkg.sv - shared constants and bypass helpers for the divide/remainder arbiter
package div_rem_pkg;

    localparam int NUM_CORES = 4;
    localparam int TIMEOUT   = 16;

    localparam logic [1:0] ORDER_DIV  = 2'b00;
    localparam logic [1:0] ORDER_DIVU = 2'b01;
    localparam logic [1:0] ORDER_REM  = 2'b10;
    localparam logic [1:0] ORDER_REMU = 2'b11;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // Signed overflow exists for both signed opcodes: INT_MIN / -1.
    function automatic logic is_overflow(input logic [1:0] order, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
        return (order != ORDER_DIVU) && (order != ORDER_REMU) &&
               (rs1 == INT_MIN) && (rs2 == ALL_ONES);
    endfunction

    function automatic logic is_bypass(input logic [1:0] order, input logic [31:0] rs1,
                                       input logic [31:0] rs2);
        return (rs2 == '0) || is_overflow(order, rs1, rs2);
    endfunction

    // Architectural result of an operation that never reaches the divider.
    function automatic logic [31:0] bypass_result(input logic [1:0] order, input logic [31:0] rs1,
                                                  input logic [31:0] rs2);
        logic is_rem;
        is_rem = (order == ORDER_REM) || (order == ORDER_REMU);
        if (rs2 == '0) begin
            return is_rem ? rs1 : ALL_ONES;
        end
        return is_rem ? 32'h0000_0000 : INT_MIN;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin arbiter, pointer moves past the winner on grant
module rr_arbiter_4
    import div_rem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] winner
);

    logic [1:0] ptr;

    // Scan from the pointer upward (wrapping) and grant the first requester.
    always_comb begin : pick
        logic       found;
        logic [1:0] idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

    // Pointer only moves when someone was granted, so idle cycles keep fairness order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (|req) begin
            ptr <= winner + 2'd1;
        end
    end

endmodule

// File: rtl/div_rem_arbiter.sv
// rtl/div_rem_arbiter.sv - shares one divider among four cores, short-circuits trivial cases
module div_rem_arbiter
    import div_rem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req_valid,
    input  logic [7:0]   req_order,
    input  logic [127:0] req_rs1,
    input  logic [127:0] req_rs2,
    output logic [3:0]   req_accept,
    output logic [3:0]   resp_valid,
    output logic [127:0] resp_data,
    output logic         div_request,
    output logic [2:0]   div_core_num,
    output logic [1:0]   div_order,
    output logic [31:0]  div_rs1,
    output logic [31:0]  div_rs2,
    input  logic [3:0]   div_ready,
    input  logic [127:0] div_ans,
    output logic [3:0]   err_timeout,
    output logic [3:0]   err_spurious
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BYPASS = 2'd1;
    localparam logic [1:0] ST_ISSUED = 2'd2;

    logic [1:0]  state   [NUM_CORES];
    logic [4:0]  cnt     [NUM_CORES];
    logic [31:0] byp_res [NUM_CORES];

    logic [3:0] eligible;
    logic [3:0] bypass;
    logic [3:0] arb_req;
    logic [3:0] grant;
    logic [1:0] winner;

    // Split idle requesters into those needing the divider and those answered locally.
    always_comb begin
        eligible = '0;
        bypass   = '0;
        arb_req  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = req_valid[i] && (state[i] == ST_IDLE);
            bypass[i]   = eligible[i] &&
                          is_bypass(req_order[2*i +: 2], req_rs1[32*i +: 32], req_rs2[32*i +: 32]);
            arb_req[i]  = eligible[i] && !bypass[i];
        end
    end

    rr_arbiter_4 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .grant  (grant),
        .winner (winner)
    );

    // Divider issue port: one-cycle strobe with operands, all zero when nothing is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_request  <= 1'b0;
            div_core_num <= '0;
            div_order    <= '0;
            div_rs1      <= '0;
            div_rs2      <= '0;
        end else if (|grant) begin
            div_request  <= 1'b1;
            div_core_num <= {1'b0, winner};
            div_order    <= req_order[{winner, 1'b0} +: 2];
            div_rs1      <= req_rs1[{winner, 5'b0} +: 32];
            div_rs2      <= req_rs2[{winner, 5'b0} +: 32];
        end else begin
            div_request  <= 1'b0;
            div_core_num <= '0;
            div_order    <= '0;
            div_rs1      <= '0;
            div_rs2      <= '0;
        end
    end

    // Per-core sequencing: accept, track the outstanding op, return results, flag errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_accept   <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            err_timeout  <= '0;
            err_spurious <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                state[i]   <= ST_IDLE;
                cnt[i]     <= '0;
                byp_res[i] <= '0;
            end
        end else begin
            req_accept <= bypass | grant;
            resp_valid <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (grant[i]) begin
                            state[i] <= ST_ISSUED;
                            cnt[i]   <= '0;
                        end else if (bypass[i]) begin
                            state[i]   <= ST_BYPASS;
                            byp_res[i] <= bypass_result(req_order[2*i +: 2], req_rs1[32*i +: 32],
                                                        req_rs2[32*i +: 32]);
                        end
                    end
                    ST_BYPASS: begin
                        state[i]            <= ST_IDLE;
                        resp_valid[i]       <= 1'b1;
                        resp_data[32*i +: 32] <= byp_res[i];
                    end
                    ST_ISSUED: begin
                        if (div_ready[i]) begin
                            state[i]              <= ST_IDLE;
                            resp_valid[i]         <= 1'b1;
                            resp_data[32*i +: 32] <= div_ans[32*i +: 32];
                        end else begin
                            // Saturate at the limit; the core stays parked until a result or reset.
                            if (cnt[i] != 5'(TIMEOUT)) begin
                                cnt[i] <= cnt[i] + 5'd1;
                            end
                            if (cnt[i] == 5'(TIMEOUT - 1)) begin
                                err_timeout[i] <= 1'b1;
                            end
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
                if (div_ready[i] && (state[i] != ST_ISSUED)) begin
                    err_spurious[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_rem_arbiter.sv
// tb/tb_div_rem_arbiter.sv - scoreboard bench for div_rem_arbiter
module tb_div_rem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [7:0]   req_order;
    logic [127:0] req_rs1;
    logic [127:0] req_rs2;
    logic [3:0]   req_accept;
    logic [3:0]   resp_valid;
    logic [127:0] resp_data;
    logic         div_request;
    logic [2:0]   div_core_num;
    logic [1:0]   div_order;
    logic [31:0]  div_rs1;
    logic [31:0]  div_rs2;
    logic [3:0]   div_ready;
    logic [127:0] div_ans;
    logic [3:0]   err_timeout;
    logic [3:0]   err_spurious;

    always #5 clk = ~clk;

    div_rem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_order    (req_order),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_accept   (req_accept),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .div_request  (div_request),
        .div_core_num (div_core_num),
        .div_order    (div_order),
        .div_rs1      (div_rs1),
        .div_rs2      (div_rs2),
        .div_ready    (div_ready),
        .div_ans      (div_ans),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          core;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          core;
        logic [1:0]  order;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } issue_t;

    resp_t  exp_resp[$];
    issue_t exp_issue[$];

    int          pend_core[$];
    logic [31:0] pend_ans[$];
    int          pend_due[$];

    int         cyc;
    logic       resp_en;
    logic [3:0] spur_mask;
    logic [3:0] s_acc, s_dreq, s_rv, s_rdy, s_to, s_sp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'b00:   model = $signed(a) / $signed(b);
            2'b01:   model = a / b;
            2'b10:   model = $signed(a) % $signed(b);
            default: model = a % b;
        endcase
    endfunction

    // Advance one cycle: sample outputs mid-cycle, act as the divider, drive inputs after the edge.
    task automatic step();
        @(negedge clk);
        s_acc  = req_accept;
        s_dreq = {3'b0, div_request};
        s_rv   = resp_valid;
        s_rdy  = div_ready;
        s_to   = err_timeout;
        s_sp   = err_spurious;
        if (div_request && resp_en) begin
            pend_core.push_back(int'(div_core_num));
            pend_ans.push_back(model(div_order, div_rs1, div_rs2));
            pend_due.push_back(cyc + 2);
        end
        @(posedge clk);
        #1;
        cyc++;
        req_valid = req_valid & ~s_acc;
        div_ready = spur_mask;
        spur_mask = '0;
        if (pend_core.size() > 0 && pend_due[0] <= cyc) begin
            div_ready[pend_core[0]]        = 1'b1;
            div_ans[32*pend_core[0] +: 32] = pend_ans[0];
            void'(pend_core.pop_front());
            void'(pend_ans.pop_front());
            void'(pend_due.pop_front());
        end
    endtask

    task automatic set_req(input int c, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        req_order[2*c +: 2] = o;
        req_rs1[32*c +: 32] = a;
        req_rs2[32*c +: 32] = b;
        req_valid[c]        = 1'b1;
    endtask

    task automatic push_issue(input int c, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue_t it;
        it.core = c; it.order = o; it.rs1 = a; it.rs2 = b;
        exp_issue.push_back(it);
    endtask

    task automatic push_resp(input int c, input logic [31:0] d);
        resp_t r;
        r.core = c; r.data = d;
        exp_resp.push_back(r);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_resp.size() > 0 || exp_issue.size() > 0) && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(exp_resp.size() + exp_issue.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_accept"}, {28'b0, req_accept}, 32'd0);
        check({name, "_resp_valid"}, {28'b0, resp_valid}, 32'd0);
        check({name, "_resp_data"}, 32'(resp_data != '0), 32'd0);
        check({name, "_div_port"}, 32'(div_request || div_core_num != '0 || div_order != '0 ||
                                       div_rs1 != '0 || div_rs2 != '0), 32'd0);
        check({name, "_err_timeout"}, {28'b0, err_timeout}, 32'd0);
        check({name, "_err_spurious"}, {28'b0, err_spurious}, 32'd0);
    endtask

    // Monitor: compares every response and divider issue against the scoreboards.
    initial begin : monitor
        int idx;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                for (int i = 0; i < 4; i++) begin
                    if (resp_valid[i]) begin
                        idx = -1;
                        for (int k = 0; k < exp_resp.size(); k++) begin
                            if (idx < 0 && exp_resp[k].core == i) idx = k;
                        end
                        if (idx < 0) begin
                            check($sformatf("unexpected_resp_core%0d", i), 32'd1, 32'd0);
                        end else begin
                            check($sformatf("resp_data_core%0d", i), resp_data[32*i +: 32], exp_resp[idx].data);
                            exp_resp.delete(idx);
                        end
                    end
                end
                if (div_request) begin
                    if (exp_issue.size() == 0) begin
                        check("unexpected_div_request", {29'b0, div_core_num}, 32'hFFFF_FFFF);
                    end else begin
                        check("issue_core", {29'b0, div_core_num}, 32'(exp_issue[0].core));
                        check("issue_order", {30'b0, div_order}, {30'b0, exp_issue[0].order});
                        check("issue_rs1", div_rs1, exp_issue[0].rs1);
                        check("issue_rs2", div_rs2, exp_issue[0].rs2);
                        void'(exp_issue.pop_front());
                    end
                end else begin
                    check("idle_issue_zero", 32'(div_core_num != '0 || div_order != '0 ||
                                                 div_rs1 != '0 || div_rs2 != '0), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] seen;
        int         n;
        reset = 1'b0; req_valid = '0; req_order = '0; req_rs1 = '0; req_rs2 = '0;
        div_ready = '0; div_ans = '0; spur_mask = '0; resp_en = 1'b1; cyc = 0;
        step();
        step();
        check_all_zero("reset_state");
        reset = 1'b1;
        step();

        // Four REMU 1000/3 in the same cycle: issued 0,1,2,3 back to back, each answers 1.
        for (int c = 0; c < 4; c++) begin
            set_req(c, 2'b11, 32'd1000, 32'd3);
            push_issue(c, 2'b11, 32'd1000, 32'd3);
            push_resp(c, 32'd1);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr_issue_strobe%0d", k), {28'b0, s_dreq}, 32'd1);
            check($sformatf("rr_accept%0d", k), {28'b0, s_acc}, 32'(1 << k));
        end
        drain("rr_drain");

        // Core0 DIV 100/7 = 14, response one cycle after div_ready.
        set_req(0, 2'b00, 32'd100, 32'd7);
        push_issue(0, 2'b00, 32'd100, 32'd7);
        push_resp(0, 32'd14);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rdy[0] && n < 30);
        check("div_ready_seen", {31'b0, s_rdy[0]}, 32'd1);
        step();
        check("div_resp_next_cycle", {31'b0, s_rv[0]}, 32'd1);
        drain("div_drain");

        // Core2 DIVU 5/0 and core1 REM INT_MIN/-1: bypass, no divider traffic.
        set_req(2, 2'b01, 32'd5, 32'd0);
        set_req(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        push_resp(2, 32'hFFFF_FFFF);
        push_resp(1, 32'h0000_0000);
        step();
        check("byp_accept_T", {28'b0, s_acc}, 32'd0);
        step();
        check("byp_accept_T1", {28'b0, s_acc}, 32'h6);
        check("byp_no_div_request", {28'b0, s_dreq}, 32'd0);
        step();
        check("byp_resp_T2", {28'b0, s_rv}, 32'h6);
        drain("byp_drain");

        // Bypass REMU x/0 and DIV overflow alongside a real DIVU on another core.
        set_req(0, 2'b11, 32'd77, 32'd0);
        set_req(3, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        set_req(1, 2'b01, 32'd9, 32'd2);
        push_issue(1, 2'b01, 32'd9, 32'd2);
        push_resp(0, 32'd77);
        push_resp(3, 32'h8000_0000);
        push_resp(1, 32'd4);
        step();
        step();
        check("mixed_accept_all", {28'b0, s_acc}, 32'hB);
        drain("mixed_drain");

        // div_ready to idle core1: no response, sticky spurious flag.
        spur_mask = 4'b0010;
        step();
        step();
        step();
        check("spurious_core1", {28'b0, s_sp}, 32'h2);

        // Core3 never answered: timeout after 16 cycles in ISSUED, no re-accept.
        resp_en = 1'b0;
        set_req(3, 2'b00, 32'd9, 32'd2);
        push_issue(3, 2'b00, 32'd9, 32'd2);
        step();
        step();
        check("to_accept", {28'b0, s_acc}, 32'h8);
        repeat (15) step();
        check("to_not_yet", {28'b0, s_to}, 32'd0);
        step();
        check("to_set", {28'b0, s_to}, 32'h8);
        set_req(3, 2'b01, 32'd20, 32'd4);
        seen = '0;
        repeat (6) begin
            step();
            seen = seen | s_acc;
        end
        check("to_no_reaccept", {31'b0, seen[3]}, 32'd0);
        req_valid[3] = 1'b0;

        // Reset while cores 0 and 2 are in flight.
        set_req(0, 2'b01, 32'd50, 32'd5);
        set_req(2, 2'b10, 32'hFFFF_FFEF, 32'd5);
        push_issue(0, 2'b01, 32'd50, 32'd5);
        push_issue(2, 2'b10, 32'hFFFF_FFEF, 32'd5);
        step();
        step();
        step();
        check("rst_both_issued", 32'(exp_issue.size()), 32'd0);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        spur_mask = 4'b0100;
        step();
        step();
        check("spur_during_reset", {28'b0, s_sp}, 32'd0);
        reset = 1'b1;
        spur_mask = 4'b0001;
        step();
        step();
        step();
        check("spur_after_release", {28'b0, s_sp}, 32'h1);
        resp_en = 1'b1;
        set_req(0, 2'b01, 32'd50, 32'd5);
        set_req(2, 2'b10, 32'hFFFF_FFEF, 32'd5);
        push_issue(0, 2'b01, 32'd50, 32'd5);
        push_issue(2, 2'b10, 32'hFFFF_FFEF, 32'd5);
        push_resp(0, 32'd10);
        push_resp(2, 32'hFFFF_FFFE);
        drain("post_reset_drain");
        repeat (4) step();
        check("final_queues_empty", 32'(exp_resp.size() + exp_issue.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
